// File: rtl/scan_counter.sv
// scan_counter: programmable-bound LED position sequencer with a tick prescaler,
// saturate / wrap / bounce / hold modes, one-hot LED decode and a boundary pulse.
module scan_counter #(
    parameter int WIDTH = 4,
    parameter int LEDS  = 8,
    parameter int PRE_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [PRE_W-1:0] prescale,
    input  logic [1:0]       mode,
    input  logic             dir_in,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic [LEDS-1:0]  leds,
    output logic             end_pulse,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        MODE_SAT    = 2'b00,
        MODE_WRAP   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    mode_t            mode_sel;
    logic [PRE_W-1:0] pre_reg,   pre_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             dir_reg,   dir_next;
    logic             pulse_reg, pulse_next;
    logic             err_reg;

    logic             bad_cfg;
    logic             flat;
    logic             run;
    logic             tick;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;
    logic [WIDTH-1:0] load_clamped;

    assign mode_sel  = mode_t'(mode);
    assign bad_cfg   = (lo > hi);
    assign flat      = (lo == hi);
    assign run       = enable && (mode_sel != MODE_HOLD);
    // >= rather than == so a prescale lowered below pre_reg ticks immediately
    assign tick      = run && (pre_reg >= prescale);
    assign count_inc = count_reg + WIDTH'(1);
    assign count_dec = count_reg - WIDTH'(1);

    always_comb begin
        load_clamped = load_val;
        if (!bad_cfg) begin
            if (load_val < lo) begin
                load_clamped = lo;
            end else if (load_val > hi) begin
                load_clamped = hi;
            end
        end
    end

    always_comb begin
        pre_next = pre_reg;
        if (load || tick) begin
            pre_next = '0;
        end else if (run) begin
            pre_next = pre_reg + PRE_W'(1);
        end
    end

    always_comb begin
        count_next = count_reg;
        dir_next   = dir_reg;
        pulse_next = 1'b0;
        if (load) begin
            count_next = load_clamped;
            dir_next   = dir_in;
        end else if (tick && !bad_cfg) begin
            // Bounds may have moved under the count: pull it back in silently first.
            if (count_reg < lo) begin
                count_next = lo;
            end else if (count_reg > hi) begin
                count_next = hi;
            end else if (flat) begin
                count_next = lo;
                if (mode_sel != MODE_BOUNCE) begin
                    dir_next = dir_in;
                end
            end else begin
                case (mode_sel)
                    MODE_SAT: begin
                        dir_next = dir_in;
                        if (!dir_in && (count_reg < hi)) begin
                            count_next = count_inc;
                            pulse_next = (count_inc == hi);
                        end else if (dir_in && (count_reg > lo)) begin
                            count_next = count_dec;
                            pulse_next = (count_dec == lo);
                        end
                    end
                    MODE_WRAP: begin
                        dir_next = dir_in;
                        if (!dir_in) begin
                            if (count_reg == hi) begin
                                count_next = lo;
                                pulse_next = 1'b1;
                            end else begin
                                count_next = count_inc;
                            end
                        end else begin
                            if (count_reg == lo) begin
                                count_next = hi;
                                pulse_next = 1'b1;
                            end else begin
                                count_next = count_dec;
                            end
                        end
                    end
                    MODE_BOUNCE: begin
                        if (!dir_reg) begin
                            if (count_reg == hi) begin
                                // parked on the top bound moving up: turn round without a pulse
                                count_next = count_dec;
                                dir_next   = 1'b1;
                            end else begin
                                count_next = count_inc;
                                if (count_inc == hi) begin
                                    dir_next   = 1'b1;
                                    pulse_next = 1'b1;
                                end
                            end
                        end else begin
                            if (count_reg == lo) begin
                                count_next = count_inc;
                                dir_next   = 1'b0;
                            end else begin
                                count_next = count_dec;
                                if (count_dec == lo) begin
                                    dir_next   = 1'b0;
                                    pulse_next = 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_reg   <= '0;
            count_reg <= '0;
            dir_reg   <= 1'b0;
            pulse_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            pre_reg   <= pre_next;
            count_reg <= count_next;
            dir_reg   <= dir_next;
            pulse_reg <= pulse_next;
            err_reg   <= bad_cfg;
        end
    end

    assign count     = count_reg;
    assign dir       = dir_reg;
    assign end_pulse = pulse_reg;
    assign cfg_err   = err_reg;

    for (genvar gi = 0; gi < LEDS; gi++) begin : g_led
        assign leds[gi] = (32'(count_reg) == gi);
    end

endmodule

// File: tb/tb_scan_counter.sv
// Self-checking bench for scan_counter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a model.
module tb_scan_counter;
    localparam int WIDTH = 4;
    localparam int LEDS  = 8;
    localparam int PRE_W = 24;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic [PRE_W-1:0] prescale = '0;
    logic [1:0]       mode = 2'b00;
    logic             dir_in = 1'b0;
    logic [WIDTH-1:0] lo = '0;
    logic [WIDTH-1:0] hi = 4'd7;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic [LEDS-1:0]  leds;
    logic             end_pulse;
    logic             cfg_err;

    int errors = 0;
    int checks = 0;

    scan_counter #(.WIDTH(WIDTH), .LEDS(LEDS), .PRE_W(PRE_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .prescale(prescale),
        .mode(mode), .dir_in(dir_in), .lo(lo), .hi(hi), .load(load),
        .load_val(load_val), .count(count), .dir(dir), .leds(leds),
        .end_pulse(end_pulse), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp, input bit verbose);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end else if (verbose) begin
            $display("ok   %s value=%0d", name, act);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, act, exp, 1'b1);
    endtask

    // Behavioural model: position arithmetic straight from the mode rules.
    int m_count = 0, m_dir = 0, m_pulse = 0, m_err = 0, m_pre = 0;
    bit model_live = 1'b0;

    always @(posedge clk) begin
        int c, l, h, tgt, n, span, p;
        bit tick;
        l = int'(lo);
        h = int'(hi);
        c = m_count;
        m_pulse = 0;
        if (reset) begin
            m_count = 0; m_dir = 0; m_err = 0; m_pre = 0;
            model_live = 1'b1;
        end else begin
            if (load) begin
                if (l > h) m_count = int'(load_val);
                else if (int'(load_val) < l) m_count = l;
                else if (int'(load_val) > h) m_count = h;
                else m_count = int'(load_val);
                m_dir = int'(dir_in);
                m_pre = 0;
            end else if (enable && mode != 2'b11) begin
                tick = (m_pre >= int'(prescale));
                m_pre = tick ? 0 : m_pre + 1;
                if (tick && l <= h) begin
                    if (c < l) m_count = l;
                    else if (c > h) m_count = h;
                    else if (l == h) begin
                        m_count = l;
                        if (mode != 2'b10) m_dir = int'(dir_in);
                    end else if (mode == 2'b00) begin
                        m_dir = int'(dir_in);
                        tgt = dir_in ? ((c - 1 < l) ? l : c - 1) : ((c + 1 > h) ? h : c + 1);
                        m_pulse = (tgt != c && tgt == (dir_in ? l : h)) ? 1 : 0;
                        m_count = tgt;
                    end else if (mode == 2'b01) begin
                        m_dir = int'(dir_in);
                        n = h - l + 1;
                        m_count = l + ((c - l) + (dir_in ? n - 1 : 1)) % n;
                        m_pulse = (dir_in ? (c == l) : (c == h)) ? 1 : 0;
                    end else begin
                        span = h - l;
                        if (c == h && m_dir == 0) begin
                            m_count = h - 1; m_dir = 1;
                        end else if (c == l && m_dir == 1) begin
                            m_count = l + 1; m_dir = 0;
                        end else begin
                            // phase around a ping-pong loop of length 2*span
                            p = (m_dir == 1) ? 2 * span - (c - l) : (c - l);
                            p = (p + 1) % (2 * span);
                            m_count = (p <= span) ? l + p : l + 2 * span - p;
                            m_dir   = (p >= span) ? 1 : 0;
                            m_pulse = (p == span || p == 0) ? 1 : 0;
                        end
                    end
                end
            end
            m_err = (l > h) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("model_count", 32'(count), 32'(m_count), 1'b0);
            check("model_dir", 32'(dir), 32'(m_dir), 1'b0);
            check("model_leds", 32'(leds), (m_count < LEDS) ? (32'd1 << m_count) : 32'd0, 1'b0);
            check("model_pulse", 32'(end_pulse), 32'(m_pulse), 1'b0);
            check("model_cfg_err", 32'(cfg_err), 32'(m_err), 1'b0);
        end
    end

    initial begin
        int e;
        int exp_c;
        int wseq[5];
        int sseq[4];
        int spul[4];
        wseq = '{2, 3, 4, 5, 2};
        sseq = '{6, 7, 7, 7};
        spul = '{0, 1, 0, 0};

        // reset state, then free-running bounce 0..7
        reset = 1'b1; enable = 1'b1; mode = 2'b10; lo = 4'd0; hi = 4'd7; prescale = '0;
        repeat (3) @(negedge clk);
        lit("rst_count", 32'(count), 32'd0);
        lit("rst_leds", 32'(leds), 32'd1);
        lit("rst_dir", 32'(dir), 32'd0);
        lit("rst_pulse", 32'(end_pulse), 32'd0);
        lit("rst_cfg_err", 32'(cfg_err), 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            exp_c = (k <= 7) ? k : 14 - k;
            lit("bounce_count", 32'(count), 32'(exp_c));
            lit("bounce_pulse", 32'(end_pulse), 32'(k == 7 || k == 14));
            lit("bounce_dir", 32'(dir), 32'(k >= 7 && k < 14));
            lit("bounce_leds", 32'(leds), 32'd1 << exp_c);
        end

        // wrap 2..5 with prescale 3 and an enable gap
        mode = 2'b01; prescale = 24'd3; lo = 4'd2; hi = 4'd5; dir_in = 1'b0;
        load = 1'b1; load_val = 4'd2;
        @(negedge clk);
        load = 1'b0;
        lit("wrap_load", 32'(count), 32'd2);
        e = 0;
        for (int c = 1; c <= 26; c++) begin
            enable = !(c >= 7 && c <= 16);
            @(negedge clk);
            if (enable) e++;
            lit("wrap_count", 32'(count), 32'(wseq[e / 4]));
            lit("wrap_pulse", 32'(end_pulse), 32'(enable && e == 16));
        end
        enable = 1'b1;

        // saturate from 5 up, then down
        mode = 2'b00; prescale = '0; lo = 4'd0; hi = 4'd7; dir_in = 1'b0;
        load = 1'b1; load_val = 4'd5;
        @(negedge clk);
        load = 1'b0;
        lit("sat_load", 32'(count), 32'd5);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            lit("sat_up_count", 32'(count), 32'(sseq[k]));
            lit("sat_up_pulse", 32'(end_pulse), 32'(spul[k]));
        end
        dir_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            lit("sat_dn_count", 32'(count), 32'(6 - k));
            lit("sat_dn_dir", 32'(dir), 32'd1);
        end

        // bounds shrink under the count, then an illegal window
        mode = 2'b10; dir_in = 1'b0; load = 1'b1; load_val = 4'd6;
        @(negedge clk);
        load = 1'b0; hi = 4'd4;
        @(negedge clk);
        lit("shrink_count", 32'(count), 32'd4);
        lit("shrink_pulse", 32'(end_pulse), 32'd0);
        lo = 4'd9; hi = 4'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            lit("cfg_err_set", 32'(cfg_err), 32'd1);
            lit("cfg_err_hold", 32'(count), 32'd4);
        end
        lo = 4'd0; hi = 4'd7;
        @(negedge clk);
        lit("cfg_err_clear", 32'(cfg_err), 32'd0);
        lit("resume_count", 32'(count), 32'd5);

        // load coinciding with a tick; first step prescale+1 cycles later
        load = 1'b1; load_val = 4'd12; lo = 4'd1; hi = 4'd9;
        @(negedge clk);
        load = 1'b0; prescale = 24'd2;
        lit("load_clamp", 32'(count), 32'd9);
        lit("load_pulse", 32'(end_pulse), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            lit("post_load_count", 32'(count), (k < 3) ? 32'd9 : 32'd8);
        end
        lit("post_load_dir", 32'(dir), 32'd1);
        lit("post_load_pulse", 32'(end_pulse), 32'd0);

        reset = 1'b1; load = 1'b1; load_val = 4'd5; lo = 4'd0; hi = 4'd7;
        @(negedge clk);
        lit("reset_over_load", 32'(count), 32'd0);
        reset = 1'b0; load = 1'b0; prescale = '0;

        // degenerate window lo == hi in each stepping mode
        lo = 4'd3; hi = 4'd3;
        for (int m = 0; m < 3; m++) begin
            mode = 2'(m); load = 1'b1; load_val = 4'd7;
            @(negedge clk);
            load = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                lit("flat_count", 32'(count), 32'd3);
                lit("flat_pulse", 32'(end_pulse), 32'd0);
            end
        end
        mode = 2'b11; lo = 4'd0; hi = 4'd7; load = 1'b1; load_val = 4'd5;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            lit("hold_count", 32'(count), 32'd5);
        end

        // randomized traffic, checked by the per-cycle compare process
        for (int i = 0; i < 4000; i++) begin
            int a, b;
            reset    = ($urandom_range(0, 199) == 0);
            load     = ($urandom_range(0, 19) == 0);
            load_val = WIDTH'($urandom_range(0, 15));
            enable   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) prescale = PRE_W'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) dir_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) begin
                a = $urandom_range(0, 15);
                b = $urandom_range(0, 15);
                if ($urandom_range(0, 7) != 0 && a > b) begin
                    lo = WIDTH'(b); hi = WIDTH'(a);
                end else begin
                    lo = WIDTH'(a); hi = WIDTH'(b);
                end
            end
            if (load || reset)
                $display("rand %0d: reset=%0d load=%0d val=%0d lo=%0d hi=%0d mode=%0d dir_in=%0d",
                         i, reset, load, load_val, lo, hi, mode, dir_in);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
